// File: rtl/gray_seq_monitor.sv
// Gray-coded count monitor: decodes samples to binary, checks single forward steps,
// counts saturating wrap-arounds and latches the first protocol violation.
module gray_seq_monitor #(
    parameter int unsigned W  = 3,
    parameter int unsigned CW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Valid,
    input  logic [W-1:0]  Gray,
    input  logic          Resync,
    output logic [W-1:0]  Bin,
    output logic          Locked,
    output logic          Wrap,
    output logic          Overflow,
    output logic [CW-1:0] WrapCount,
    output logic          Error,
    output logic [1:0]    ErrCode
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_ERROR    = 2'b10
    } state_t;

    localparam logic [1:0]   ERR_NONE = 2'b00;
    localparam logic [1:0]   ERR_BACK = 2'b01;
    localparam logic [1:0]   ERR_JUMP = 2'b10;
    localparam logic [W-1:0] STEP_FWD = W'(1);
    localparam logic [W-1:0] STEP_BCK = '1;

    state_t        state_q, state_d;
    logic [W-1:0]  bin_q, bin_d;
    logic          wrap_q, wrap_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic [W-1:0]  dec;
    logic [W-1:0]  delta;

    always_comb begin
        dec        = '0;
        dec[W-1]   = Gray[W-1];
        for (int unsigned k = 1; k < W; k++) begin
            dec[W-1-k] = dec[W-k] ^ Gray[W-1-k];
        end
    end

    // bin_q doubles as the previous sample for the step check
    assign delta = dec - bin_q;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        code_d  = code_q;

        if (Valid) begin
            bin_d = dec;
        end

        if (Resync) begin
            err_d   = 1'b0;
            code_d  = ERR_NONE;
            state_d = Valid ? ST_LOCKED : ST_UNLOCKED;
        end else if (Valid) begin
            case (state_q)
                ST_UNLOCKED: state_d = ST_LOCKED;
                ST_LOCKED: begin
                    if (delta == STEP_FWD) begin
                        if (dec == '0) begin
                            wrap_d = 1'b1;
                            ovf_d  = 1'b1;
                            if (wcnt_q != '1) begin
                                wcnt_d = wcnt_q + CW'(1);
                            end
                        end
                    end else if (delta == STEP_BCK) begin
                        err_d   = 1'b1;
                        code_d  = ERR_BACK;
                        state_d = ST_ERROR;
                    end else if (delta != '0) begin
                        err_d   = 1'b1;
                        code_d  = ERR_JUMP;
                        state_d = ST_ERROR;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_UNLOCKED;
            bin_q   <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign Bin       = bin_q;
    assign Locked    = (state_q == ST_LOCKED);
    assign Wrap      = wrap_q;
    assign Overflow  = ovf_q;
    assign WrapCount = wcnt_q;
    assign Error     = err_q;
    assign ErrCode   = code_q;

endmodule
